// File: rtl/pmem_responder_pkg.sv
// Shared definitions for the 256-bit line memory responder and its clients.
package pmem_responder_pkg;

  localparam int unsigned LINE_W = 256;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: one synchronous write port, one combinational read port, no reset.
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  line_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output line_t            rdata
);

  line_t mem [LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder with sticky protocol-error flag.
// Define PMEM_RESPONDER_CHECK_EN to also flag request changes while BUSY.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              pmem_err
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  state_t           state, state_nx;
  logic [7:0]       cnt, cnt_nx;
  logic             op_wr_q;
  logic [IDX_W-1:0] idx_q;
  line_t            wdata_q;
  line_t            arr_rdata;
  logic             err_q;
  logic             accept;
  logic             held;
  logic             err_set;
  logic             chk_err;
  logic             unused_addr;

  // Only the line index bits of the address select storage; the rest alias.
  assign unused_addr = ^{pmem_address[4:0], pmem_address[31:5+IDX_W]};

  assign held = op_wr_q ? pmem_write : pmem_read;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_read ^ pmem_write) begin
          accept   = 1'b1;
          cnt_nx   = LAT_M1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!held) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef PMEM_RESPONDER_CHECK_EN
  logic [31:0] addr_q;

  always_ff @(posedge clk) begin
    if (accept) addr_q <= pmem_address;
  end

  // An abort (request dropped) is legal; only changes under a held request are errors.
  assign chk_err = (state == BUSY) && held &&
                   ((pmem_address != addr_q) ||
                    (op_wr_q ? (pmem_read || (pmem_wdata != wdata_q)) : pmem_write));
`else
  assign chk_err = 1'b0;
`endif

  assign err_set = ((state == IDLE) && pmem_read && pmem_write) || chk_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_q | err_set;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr_q <= pmem_write;
      idx_q   <= pmem_address[5 +: IDX_W];
      if (pmem_write) wdata_q <= pmem_wdata;
    end
  end

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    ((state == RESP) && op_wr_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );

  assign pmem_resp  = (state == RESP);
  assign pmem_rdata = ((state == RESP) && !op_wr_q) ? arr_rdata : '0;
  assign pmem_err   = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder against a line-array reference model.
module tb_pmem_responder;

  localparam int unsigned LAT = 10;
  localparam int unsigned NL  = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] model    [NL];
  bit           model_ok [NL];

  always #5 clk = ~clk;

  pmem_responder #(
    .LATENCY (LAT),
    .LINES   (NL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_err     (pmem_err)
  );

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 32) % NL;
  endfunction

  // One full transaction; checks latency, idle rdata, read data against the model.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                         input string name);
    int k;
    bit seen;
    logic [255:0] got;
    int unsigned ln;
    ln = line_of(addr);
    seen = 0;
    got = '0;
    @(negedge clk);
    pmem_address = addr;
    pmem_write   = wr;
    pmem_read    = !wr;
    pmem_wdata   = data;
    for (k = 1; k <= int'(LAT) + 20; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        seen = 1;
        got  = pmem_rdata;
        break;
      end
      n_checks++;
      if (pmem_rdata !== '0) begin
        n_fail++;
        $display("FAIL %s rdata_while_no_resp: got %h required 0", name, pmem_rdata);
      end
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    n_checks++;
    if (!seen || (k - 1) != int'(LAT)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (seen=%0d) required %0d", name, k - 1, seen, LAT);
    end
    if (seen && !wr && model_ok[ln]) begin
      n_checks++;
      if (got !== model[ln]) begin
        n_fail++;
        $display("FAIL %s rdata line %0d: got %h required %h", name, ln, got, model[ln]);
      end
    end
    if (seen && wr) begin
      model[ln]    = data;
      model_ok[ln] = 1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0) begin
      n_fail++;
      $display("FAIL %s after_resp: resp=%b rdata=%h required resp=0 rdata=0",
               name, pmem_resp, pmem_rdata);
    end
  endtask

  task automatic expect_no_resp(input int cycles, input string name);
    bit any;
    any = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (pmem_resp) any = 1;
    end
    n_checks++;
    if (any) begin
      n_fail++;
      $display("FAIL %s no_resp: got resp pulse required none", name);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    for (int i = 0; i < NL; i++) model_ok[i] = 0;
    #1;
    n_checks++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0 || pmem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: resp=%b err=%b rdata=%h required 0/0/0",
               pmem_resp, pmem_err, pmem_rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_txn(1, 32'h4000_8000, 256'h1111, "preload_write");
    run_txn(0, 32'h4000_8000, '0, "read_1111");
    run_txn(1, 32'h4001_8042, 256'hf222, "offset_write");
    run_txn(0, 32'h4001_8040, '0, "offset_read");
    run_txn(1, 32'h0000_0020, 256'hAAAA, "alias_write");
    run_txn(0, 32'h0000_0220, '0, "alias_read");
    n_checks++;
    if (pmem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_after_legal: got %b required 0", pmem_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < int'(NL); i++)
      run_txn(1, $urandom & 32'hffff_ffe0 | (i * 32), {8{$urandom()}}, "fill");
    for (int i = 0; i < 50; i++)
      run_txn(bit'($urandom_range(0, 1)), $urandom, {8{$urandom()}}, "random");
  endtask

  task automatic test_abort();
    logic [31:0] a;
    a = 32'h0000_0160;
    run_txn(1, a, 256'h1234_5678, "abort_setup");
    @(negedge clk);
    pmem_address = a;
    pmem_read    = 1'b1;
    repeat (4) @(posedge clk);
    #1 pmem_read = 1'b0;
    expect_no_resp(LAT + 5, "abort_read");
    @(negedge clk);
    pmem_write = 1'b1;
    pmem_wdata = 256'hdead_beef;
    repeat (4) @(posedge clk);
    #1 pmem_write = 1'b0;
    expect_no_resp(LAT + 5, "abort_write");
    run_txn(0, a, '0, "abort_readback");
  endtask

  task automatic test_back_to_back();
    int k;
    bit seen;
    logic [31:0] a;
    a = 32'h0000_01a0;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        @(negedge clk);
        pmem_address = a;
        pmem_read    = 1'b1;
      end
      seen = 0;
      for (k = 1; k <= int'(LAT) + 20; k++) begin
        @(posedge clk); #1;
        if (pmem_resp) begin
          seen = 1;
          break;
        end
      end
      n_checks++;
      if (!seen || k != ((t == 0) ? int'(LAT) + 1 : int'(LAT) + 2)) begin
        n_fail++;
        $display("FAIL b2b_gap%0d: got %0d (seen=%0d) required %0d", t, k, seen,
                 (t == 0) ? LAT + 1 : LAT + 2);
      end
      n_checks++;
      if (seen && pmem_rdata !== model[line_of(a)]) begin
        n_fail++;
        $display("FAIL b2b_data%0d: got %h required %h", t, pmem_rdata, model[line_of(a)]);
      end
    end
    pmem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    bit any;
    @(negedge clk);
    pmem_address = 32'h0000_0040;
    pmem_read    = 1'b1;
    pmem_write   = 1'b1;
    any = 0;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
      if (pmem_resp) any = 1;
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    n_checks++;
    if (any || pmem_err !== 1'b1) begin
      n_fail++;
      $display("FAIL both_ops: resp_seen=%b err=%b required 0/1", any, pmem_err);
    end
    run_txn(0, 32'h0000_0040, '0, "after_err_read");
    n_checks++;
    if (pmem_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b required 1", pmem_err);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pmem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: got %b required 0", pmem_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    bit seen;
    a = 32'h0000_00c0;
    run_txn(1, a, 256'h7777, "rst_setup");
    @(negedge clk);
    pmem_address = a;
    pmem_write   = 1'b1;
    pmem_wdata   = 256'h5555;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (pmem_resp !== 1'b0 || pmem_rdata !== '0 || pmem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: resp=%b err=%b rdata=%h required 0/0/0",
               pmem_resp, pmem_err, pmem_rdata);
    end
    @(negedge clk);
    pmem_write = 1'b0;
    rst_n      = 1'b1;
    run_txn(0, a, '0, "rst_busy_readback");
    @(negedge clk);
    pmem_address = a;
    pmem_write   = 1'b1;
    pmem_wdata   = 256'h9999;
    seen = 0;
    for (int k = 0; k < int'(LAT) + 20; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        seen = 1;
        break;
      end
    end
    rst_n      = 1'b0;
    pmem_write = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_resp_setup: got no resp required resp");
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(0, a, '0, "rst_resp_readback");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
